// File: rtl/queue_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
//
// Shared types and constants for the FIFO queue family.
//
// Contents:
//   READER_SLOTS  - depth of the queue_reader skid buffer
//   occ_state_t   - queue_reader occupancy state (EMPTY / ONE / TWO)
//   occupancy()   - number of buffered entries encoded by an occ_state_t
// ---------------------------------------------------------------------------
package queue_pkg;

    localparam int READER_SLOTS = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    function automatic logic [1:0] occupancy(input occ_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage : queue_pkg

// File: rtl/queue_reader.sv
// ---------------------------------------------------------------------------
// queue_reader
//
// Read-side engine for a FIFO queue's pop interface. Entries are popped
// whenever the local 2-entry skid buffer can take them and are presented
// on a registered valid/ready port. out_valid/out_data come from flops
// only; q_pop depends on out_ready through a single gate.
//
// Parameters:
//   WIDTH        data width, must match the attached queue
//
// Ports:
//   clk0         clock
//   rst0         synchronous active-high reset (drops buffered entries)
//   flush        discard all buffered entries, no pop this cycle
//   q_empty      queue empty flag
//   q_pop_data   queue head data, valid together with q_pop_resp
//   q_pop_resp   queue acknowledges the pop this cycle
//   q_pop        pop request to the queue (combinational)
//   out_valid    out_data holds a valid entry
//   out_data     oldest buffered entry
//   out_ready    consumer accepts the entry this cycle
//
// Optional build macro QUEUE_READER_STATS_EN adds:
//   pop_count    captures since reset (wraps at 2^32)
//   stall_cycles cycles with out_valid && !out_ready since reset
// Neither counter is cleared by flush.
// ---------------------------------------------------------------------------
module queue_reader
    import queue_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             flush,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_pop_data,
    input  logic             q_pop_resp,
    output logic             q_pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef QUEUE_READER_STATS_EN
    ,
    output logic [31:0]      pop_count,
    output logic [31:0]      stall_cycles
`endif
);

    occ_state_t       state_q, state_d;
    logic             head_q, head_d;
    logic [WIDTH-1:0] slot_q [READER_SLOTS];

    logic             capture;
    logic             deq;
    logic [1:0]       occ;
    logic             wr_idx;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // In TWO a pop is only allowed when the head entry leaves in the same
    // cycle, so the incoming word always has a free slot.
    assign q_pop   = !rst0 && !flush && !q_empty && (state_q != TWO || out_ready);
    assign capture = q_pop && q_pop_resp;

    // A dequeue during flush has no effect on state or head.
    assign deq     = out_valid && out_ready && !flush;

    // Write slot is (head + occupancy) mod 2 using the current head, which
    // equals (next head + occupancy - deq). In TWO with deq this is the
    // slot being vacated by the departing head entry.
    assign occ     = occupancy(state_q);
    assign wr_idx  = head_q ^ occ[0];

    assign out_valid = (state_q != EMPTY);
    assign out_data  = slot_q[head_q];

    // ------------------------------------------------------------------
    // Occupancy FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_d = state_q;
        head_d  = head_q;

        if (flush) begin
            state_d = EMPTY;
            head_d  = 1'b0;
        end else begin
            if (deq) begin
                head_d = ~head_q;
            end

            unique case (state_q)
                EMPTY: begin
                    if (capture) begin
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (capture && !deq) begin
                        state_d = TWO;
                    end else if (!capture && deq) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deq && !capture) begin
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, head pointer and slot storage
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= EMPTY;
            head_q  <= 1'b0;
            // NOTE: the two slots are reset because out_data is a direct
            // view of slot[head] and must read zero out of reset.
            for (int i = 0; i < READER_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            if (capture) begin
                slot_q[wr_idx] <= q_pop_data;
            end
        end
    end

`ifdef QUEUE_READER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (cleared by reset only, not by flush)
    // ------------------------------------------------------------------
    logic [31:0] pop_count_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            pop_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (capture) begin
                pop_count_q <= pop_count_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign pop_count    = pop_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule : queue_reader

// File: tb/tb_queue_reader.sv
// ---------------------------------------------------------------------------
// tb_queue_reader
//
// Self-checking bench for queue_reader. A small behavioural 8-entry queue
// (NUM_BITS = 3) feeds the reader; every word pushed into it is also pushed
// onto a scoreboard, and each output handshake pops and compares the
// oldest expected word. Entries dropped by flush/reset are removed from the
// scoreboard by the directed sequence. Define QUEUE_READER_STATS_EN to
// exercise the statistics counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_queue_reader;
    import queue_pkg::*;

    localparam int WIDTH = 32;

    logic             clk0;
    logic             rst0;
    logic             flush;
    logic             q_empty;
    logic [WIDTH-1:0] q_pop_data;
    logic             q_pop_resp;
    logic             q_pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef QUEUE_READER_STATS_EN
    logic [31:0]      pop_count;
    logic [31:0]      stall_cycles;
`endif

    queue_reader #(.WIDTH(WIDTH)) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .flush       (flush),
        .q_empty     (q_empty),
        .q_pop_data  (q_pop_data),
        .q_pop_resp  (q_pop_resp),
        .q_pop       (q_pop),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef QUEUE_READER_STATS_EN
        ,
        .pop_count   (pop_count),
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // ------------------------------------------------------------------
    // Behavioural source queue, 8 entries
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] qmem [8];
    logic [2:0]       rd_ptr   = 3'd0;
    logic [2:0]       wr_ptr   = 3'd0;
    logic [3:0]       q_count  = 4'd0;
    logic             push_en  = 1'b0;
    logic [WIDTH-1:0] push_data = '0;

    assign q_empty    = (q_count == 4'd0);
    assign q_pop_data = qmem[rd_ptr];
    assign q_pop_resp = q_pop && !q_empty;

    always @(posedge clk0) begin
        if (push_en) begin
            qmem[wr_ptr] <= push_data;
            wr_ptr       <= wr_ptr + 3'd1;
        end
        if (q_pop_resp) begin
            rd_ptr <= rd_ptr + 3'd1;
        end
        q_count <= q_count + {3'd0, push_en} - {3'd0, q_pop_resp};
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] exp_q [$];
    int n_checks = 0;
    int n_err    = 0;
    int run      = 0;
    int last_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Output monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk0) begin
        logic [WIDTH-1:0] e;
        if (out_valid) begin
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (out_valid && out_ready && !flush && !rst0) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", out_data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        push_en   = 1'b1;
        push_data = w;
        exp_q.push_back(w);
        tick();
        push_en   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            tick();
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst0      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_q_pop",     {31'd0, q_pop}, 32'd0);

        // q_pop held low by reset even with data waiting
        push_word(32'hA5A5_0001);
        check("rst_blocks_pop", {31'd0, q_pop}, 32'd0);

        // Single transfer
        rst0      = 1'b0;
        out_ready = 1'b1;
        #1;
        check("single_pop_req", {31'd0, q_pop}, 32'd1);
        tick();
        check("single_valid",  {31'd0, out_valid}, 32'd1);
        check("single_data",   out_data, 32'hA5A5_0001);
        check("single_q_empty", {31'd0, q_empty}, 32'd1);
        check("single_pop_once", {31'd0, q_pop}, 32'd0);
        drain("single_drain");
        tick();

        // Streaming 8 words, no bubbles
        for (int i = 0; i < 8; i++) begin
            push_word(32'h10 + 32'(i));
        end
        drain("stream_drain");
        tick();
        check("stream_run_len", 32'(last_run), 32'd8);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(32'h20 + 32'(i));
        end
        check("bp_q_pop",     {31'd0, q_pop}, 32'd0);
        check("bp_q_nonempty", {31'd0, q_empty}, 32'd0);
        check("bp_valid",     {31'd0, out_valid}, 32'd1);
        check("bp_data",      out_data, 32'h20);
        tick();
        check("bp_data_hold", out_data, 32'h20);
        check("bp_q_count",   {28'd0, q_count}, 32'd2);
        out_ready = 1'b1;
        drain("bp_drain");

        // Flush while in TWO with the queue non-empty
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(32'h30 + 32'(i));
        end
        check("flush_pre_q_count", {28'd0, q_count}, 32'd2);
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush_no_pop", {31'd0, q_pop}, 32'd0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        check("flush_valid",   {31'd0, out_valid}, 32'd0);
        check("flush_q_count", {28'd0, q_count}, 32'd2);
        out_ready = 1'b1;
        tick();
        check("flush_next_valid", {31'd0, out_valid}, 32'd1);
        check("flush_next_data",  out_data, 32'h32);
        drain("flush_drain");

        // Reset while in ONE
        out_ready = 1'b0;
        push_word(32'h40);
        tick();
        check("mid_rst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst0 = 1'b1;
        push_word(32'h41);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data",  out_data, 32'd0);
        check("mid_rst_q_pop", {31'd0, q_pop}, 32'd0);
        push_word(32'h42);
        void'(exp_q.pop_front());
        rst0      = 1'b0;
        out_ready = 1'b1;
        drain("mid_rst_drain");

`ifdef QUEUE_READER_STATS_EN
        // Statistics: 4 pops, 3 stall cycles, unaffected by flush
        rst0 = 1'b1;
        tick();
        tick();
        rst0 = 1'b0;
        check("stats_rst_pops",   pop_count, 32'd0);
        check("stats_rst_stalls", stall_cycles, 32'd0);
        out_ready = 1'b0;
        push_word(32'h50);
        tick();
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            push_word(32'h50 + 32'(i));
        end
        drain("stats_drain");
        check("stats_pops",   pop_count, 32'd4);
        check("stats_stalls", stall_cycles, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("stats_flush_pops",   pop_count, 32'd4);
        check("stats_flush_stalls", stall_cycles, 32'd3);
`endif

        check("end_q_empty", {31'd0, q_empty}, 32'd1);
        check("end_idle",    {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_queue_reader
